// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer, occupancy and flag controller for the 128 x 8 FIFO array.
// Define FIFO_ALMOST_FLAGS_EN to add the registered almost_full / almost_empty outputs.
module fifo_ptr_ctrl #(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DEPTH    = 2**ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   parameter int unsigned AF_LEVEL = 120,
   parameter int unsigned AE_LEVEL = 8
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic              rd_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
`ifdef FIFO_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic              underflow
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [CNT_W-1:0] count_nxt;
   logic             full_nxt;
   logic             empty_nxt;

   // Accept decode and next occupancy; flags are decoded from the next count
   always_comb begin
      wr_en     = wr_req & ~full  & ~rst;
      rd_en     = rd_req & ~empty & ~rst;
      count_nxt = count;
      unique case ({wr_en, rd_en})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      full_nxt  = (count_nxt == CNT_W'(DEPTH));
      empty_nxt = (count_nxt == '0);
   end

   // Pointers wrap naturally at 2**ADDR_W
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr   <= '0;
         rd_addr   <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
         if (rd_en) rd_addr <= rd_addr + ADDR_W'(1);
         count     <= count_nxt;
         full      <= full_nxt;
         empty     <= empty_nxt;
         overflow  <= wr_req & full;
         underflow <= rd_req & empty;
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
         almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
      end
   end
`endif

endmodule
